// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared command codes, FSM encoding, DDRAM line map and busy defaults
package lcd_pkg;

    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] CMD_ENTRY     = 8'h04;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

    localparam logic [6:0] LINE1_END   = 7'h27;
    localparam logic [6:0] LINE2_START = 7'h40;
    localparam logic [6:0] LINE2_END   = 7'h67;

    localparam int BUSY_SHORT_DEF = 2000;
    localparam int BUSY_LONG_DEF  = 82000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_BUSY    = 2'd2
    } state_t;

    // The two display lines are joined end-to-end into one 80-character ring.
    function automatic logic [6:0] step_addr(input logic [6:0] addr, input logic inc);
        if (inc) begin
            if (addr == LINE1_END) return LINE2_START;
            if (addr == LINE2_END) return 7'h00;
            return addr + 7'd1;
        end
        if (addr == 7'h00) return LINE2_END;
        if (addr == LINE2_START) return LINE1_END;
        return addr - 7'd1;
    endfunction

endpackage

// File: rtl/lcd_strobe_sync.sv
// rtl/lcd_strobe_sync.sv - two-flop synchroniser and falling-edge detector for the enable strobe
module lcd_strobe_sync (
    input  logic clk,
    input  logic Reset,
    input  logic en_async,
    output logic fall
);

    // [0],[1] synchronise; [2] is the previous synchronised level.
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], en_async};
        end
    end

    assign fall = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/lcd_rx_responder.sv
// rtl/lcd_rx_responder.sv - HD44780-style bus responder; LCD_RX_BUSY_EN enables busy timing and overrun
module lcd_rx_responder
    import lcd_pkg::*;
#(
    parameter int BUSY_SHORT = BUSY_SHORT_DEF,
    parameter int BUSY_LONG  = BUSY_LONG_DEF
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       rs_i,
    input  logic       rw_i,
    input  logic       en_i,
    input  logic [7:0] Data,
    output logic       busy_o,
    output logic [7:0] status_o,
    output logic       cmd_valid_o,
    output logic [7:0] cmd_o,
    output logic       char_valid_o,
    output logic [7:0] char_o,
    output logic       overrun_o
);

    state_t     state_q, state_d;
    logic [6:0] addr_q, addr_d;
    logic       inc_q, inc_d;
    logic       rs_q, rs_d;
    logic [7:0] byte_q, byte_d;
    logic       cmd_valid_d, char_valid_d;
    logic [7:0] cmd_d, char_d;
    logic       strobe_fall;
    logic       write_fall;

    lcd_strobe_sync u_sync (
        .clk      (clk),
        .Reset    (Reset),
        .en_async (en_i),
        .fall     (strobe_fall)
    );

    assign write_fall = strobe_fall & ~rw_i;
    assign busy_o     = (state_q != ST_IDLE);
    assign status_o   = {busy_o, addr_q};

`ifdef LCD_RX_BUSY_EN
    logic [31:0] cnt_q;
    logic        long_cmd;
    logic        busy_done;
    logic        overrun_q;

    assign long_cmd  = !rs_q && ((byte_q == CMD_CLEAR) || (byte_q[7:1] == CMD_HOME[7:1]));
    assign busy_done = (cnt_q == '0);

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else if (state_q == ST_CAPTURE) begin
            cnt_q <= long_cmd ? 32'(BUSY_LONG - 1) : 32'(BUSY_SHORT - 1);
        end else if (state_q == ST_BUSY && !busy_done) begin
            cnt_q <= cnt_q - 32'd1;
        end
    end

    // A write seen in the last busy cycle still counts as a collision.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            overrun_q <= 1'b0;
        end else if (write_fall && state_q != ST_IDLE) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun_o = overrun_q;
`else
    logic unused_busy_cfg;
    assign unused_busy_cfg = ^{BUSY_SHORT, BUSY_LONG};
    assign overrun_o       = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        inc_d        = inc_q;
        rs_d         = rs_q;
        byte_d       = byte_q;
        cmd_valid_d  = 1'b0;
        char_valid_d = 1'b0;
        cmd_d        = cmd_o;
        char_d       = char_o;
        case (state_q)
            ST_IDLE: begin
                if (write_fall) begin
                    state_d = ST_CAPTURE;
                    rs_d    = rs_i;
                    byte_d  = Data;
                end
            end
            ST_CAPTURE: begin
                if (rs_q) begin
                    char_valid_d = 1'b1;
                    char_d       = byte_q;
                    addr_d       = step_addr(addr_q, inc_q);
                end else begin
                    cmd_valid_d = 1'b1;
                    cmd_d       = byte_q;
                    if (byte_q == CMD_CLEAR) begin
                        addr_d = 7'h00;
                        inc_d  = 1'b1;
                    end else if (byte_q[7:1] == CMD_HOME[7:1]) begin
                        addr_d = 7'h00;
                    end else if (byte_q[7:2] == CMD_ENTRY[7:2]) begin
                        inc_d = byte_q[1];
                    end else if (byte_q[7] == CMD_SET_DDRAM[7]) begin
                        addr_d = byte_q[6:0];
                    end
                end
`ifdef LCD_RX_BUSY_EN
                state_d = ST_BUSY;
`else
                state_d = ST_IDLE;
`endif
            end
`ifdef LCD_RX_BUSY_EN
            ST_BUSY: begin
                if (busy_done) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= 7'h00;
            inc_q        <= 1'b1;
            rs_q         <= 1'b0;
            byte_q       <= 8'h00;
            cmd_valid_o  <= 1'b0;
            char_valid_o <= 1'b0;
            cmd_o        <= 8'h00;
            char_o       <= 8'h00;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            inc_q        <= inc_d;
            rs_q         <= rs_d;
            byte_q       <= byte_d;
            cmd_valid_o  <= cmd_valid_d;
            char_valid_o <= char_valid_d;
            cmd_o        <= cmd_d;
            char_o       <= char_d;
        end
    end

endmodule
